if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the instruction driven when no valid instruction is presented.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 jump_en_i  input  1  redirect request from execute stage.
REQ-006 jump_addr_i  input  32  redirect target.
REQ-007 hold_i  input  1  downstream stall; head instruction is not consumed while high.
REQ-008 mem_req_o  output  1  instruction-memory read request.
REQ-009 mem_addr_o  output  32  request address, word aligned.
REQ-010 mem_gnt_i  input  1  request accepted this cycle when high with mem_req_o.
REQ-011 mem_rvalid_i  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-012 mem_rdata_i  input  32  read data.
REQ-013 inst_o  output  32  instruction to decode.
REQ-014 inst_addr_o  output  32  address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o/inst_addr_o are valid this cycle.

Function
REQ-016 Fetch PC register holds the address of the next request; mem_addr_o SHALL equal the PC with bits [1:0] forced to 0.
REQ-017 On grant (mem_req_o && mem_gnt_i) the PC SHALL advance by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and the address SHALL be pushed onto an in-flight address queue.
REQ-018 Instruction buffer: 2-entry FIFO of {addr, inst}; in-flight count plus buffer occupancy SHALL never exceed 2.
REQ-019 mem_req_o SHALL be high iff not in reset, jump_en_i is low, and in-flight + buffered < 2.
REQ-020 mem_req_o and mem_addr_o SHALL remain stable until granted, except on jump_en_i or rst.
REQ-021 A non-discarded response SHALL be written to the buffer with the oldest in-flight address; it becomes visible on outputs the following cycle (minimum grant-to-inst_valid_o latency 2 cycles).
REQ-022 inst_valid_o SHALL equal (buffer not empty && !jump_en_i); inst_o/inst_addr_o SHALL show the buffer head, or NOP_INST/inst_addr 0 when inst_valid_o is low.
REQ-023 Buffer head SHALL pop when inst_valid_o && !hold_i; simultaneous pop and write SHALL be supported at full occupancy-equivalent (throughput 1 instruction/cycle with single-cycle memory).
REQ-024 jump_en_i SHALL, in that cycle: clear the buffer, suppress any pop, load PC with {jump_addr_i[31:2],2'b00}, and set discard count to in-flight count minus any response arriving that same cycle (that response is also discarded).
REQ-025 While discard count is non-zero, each mem_rvalid_i SHALL decrement it and SHALL NOT be written to the buffer; new requests MAY issue subject to REQ-018/019, discarded slots counting as in-flight.
REQ-026 State machine: RESET (rst high) -> RUN (normal fetch) -> DRAIN (discard count > 0, entered by jump with in-flight > 0) -> RUN when discard count reaches 0; jump in DRAIN reloads PC and adds the newly killed in-flight requests to discard count.
REQ-027 hold_i SHALL NOT block fetch; fetching continues until buffer+in-flight is full.
REQ-028 mem_rvalid_i with zero in-flight requests SHALL be ignored.

Reset
REQ-029 While rst high: PC = RESET_ADDR, buffer empty, in-flight 0, discard 0, state RESET, mem_req_o = 0, inst_valid_o = 0, inst_o = NOP_INST, inst_addr_o = 0.
REQ-030 First request SHALL be issued the first cycle rst is low, with mem_addr_o = RESET_ADDR.
REQ-031 rst asserted mid-operation SHALL abandon all in-flight and buffered entries; responses arriving during or after reset for pre-reset requests are the memory model's responsibility and SHALL be ignored while rst is high.

Verification
REQ-032 Reset release, memory grants every cycle, rvalid 1 cycle later -> inst_addr_o 0,4,8,12 on consecutive cycles starting 2 cycles after first grant.
REQ-033 hold_i high 3 cycles with head 0x8 -> inst_o/addr stay at 0x8, mem_req_o drops when 2 entries held, resumes with 0x10 after hold_i low.
REQ-034 jump_en_i to 0x0000_0102 with 2 requests in flight -> both responses discarded, next mem_addr_o 0x100, first inst_addr_o 0x100, no stale address ever valid.
REQ-035 mem_gnt_i low 4 cycles -> mem_addr_o stable at 0x0, no duplicate or skipped addresses after grant.
REQ-036 PC 0xFFFF_FFFC granted -> next mem_addr_o 0x0000_0000.
REQ-037 rst pulsed 1 cycle with buffer full -> inst_valid_o low next cycle, refetch from RESET_ADDR.

Source files
------------

// File: rtl/if_fetch_if.sv
// Handshake bundle between the fetch unit, the instruction memory, decode and execute.
// The master modport is the fetch unit's view.
interface if_fetch_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  modport master (
    input  jump_en_i, jump_addr_i, hold_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );

  modport slave (
    output jump_en_i, jump_addr_i, hold_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: at most two requests in flight or buffered, a two-entry instruction
// buffer, and redirects that silently drop responses to requests issued before the jump.
module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  infl_q, infl_d;
  logic [1:0]  disc_q, disc_d;
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [31:0] aq_q [2];
  logic [31:0] aq_d [2];
  logic [31:0] buf_addr_q [2];
  logic [31:0] buf_addr_d [2];
  logic [31:0] buf_inst_q [2];
  logic [31:0] buf_inst_d [2];

  logic       valid_s, pop_s, req_s, gnt_s, rsp_s, draining_s;
  logic       aq_idx_s, buf_idx_s;
  logic [1:0] occ_s;

  // Occupancy counts the slot freed by a same-cycle pop so a 1-cycle memory streams at full rate.
  assign valid_s    = !rst && (buf_cnt_q != 2'd0) && !bus.jump_en_i;
  assign pop_s      = valid_s && !bus.hold_i;
  assign occ_s      = infl_q + buf_cnt_q - {1'b0, pop_s};
  assign req_s      = !rst && !bus.jump_en_i && (occ_s < 2'd2);
  assign gnt_s      = req_s && bus.mem_gnt_i;
  assign rsp_s      = bus.mem_rvalid_i && (infl_q != 2'd0);
  assign draining_s = (state_q == ST_DRAIN);
  assign aq_idx_s   = infl_q[0] && !rsp_s;
  assign buf_idx_s  = buf_cnt_q[0] && !pop_s;

  assign bus.mem_req_o    = req_s;
  assign bus.mem_addr_o   = {pc_q[31:2], 2'b00};
  assign bus.inst_valid_o = valid_s;
  assign bus.inst_o       = valid_s ? buf_inst_q[0] : NOP_INST;
  assign bus.inst_addr_o  = valid_s ? buf_addr_q[0] : 32'h0000_0000;

  // Next-state for PC, in-flight address queue, instruction buffer and discard bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    infl_d     = infl_q + {1'b0, gnt_s} - {1'b0, rsp_s};
    disc_d     = disc_q;
    buf_cnt_d  = buf_cnt_q;
    state_d    = state_q;
    aq_d       = aq_q;
    buf_addr_d = buf_addr_q;
    buf_inst_d = buf_inst_q;

    if (rsp_s) begin
      aq_d[0] = aq_q[1];
    end else begin
      aq_d[0] = aq_q[0];
    end
    if (gnt_s) begin
      aq_d[aq_idx_s] = {pc_q[31:2], 2'b00};
      pc_d           = {pc_q[31:2], 2'b00} + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    if (bus.jump_en_i) begin
      // Every request still outstanding after this cycle's response belongs to the old path.
      pc_d      = {bus.jump_addr_i[31:2], 2'b00};
      buf_cnt_d = 2'd0;
      disc_d    = infl_q - {1'b0, rsp_s};
    end else begin
      if (pop_s) begin
        buf_addr_d[0] = buf_addr_q[1];
        buf_inst_d[0] = buf_inst_q[1];
      end else begin
        buf_addr_d[0] = buf_addr_q[0];
        buf_inst_d[0] = buf_inst_q[0];
      end
      if (rsp_s && draining_s) begin
        disc_d    = disc_q - 2'd1;
        buf_cnt_d = buf_cnt_q - {1'b0, pop_s};
      end else if (rsp_s) begin
        buf_addr_d[buf_idx_s] = aq_q[0];
        buf_inst_d[buf_idx_s] = bus.mem_rdata_i;
        buf_cnt_d             = buf_cnt_q + 2'd1 - {1'b0, pop_s};
      end else begin
        buf_cnt_d = buf_cnt_q - {1'b0, pop_s};
      end
    end

    if (disc_d != 2'd0) begin
      state_d = ST_DRAIN;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Control state with synchronous reset; reset abandons all in-flight and buffered work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      pc_q      <= RESET_ADDR;
      infl_q    <= 2'd0;
      disc_q    <= 2'd0;
      buf_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      disc_q    <= disc_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  // Payload storage is qualified by the counters above and needs no reset.
  always_ff @(posedge clk) begin
    aq_q       <= aq_d;
    buf_addr_q <= buf_addr_d;
    buf_inst_q <= buf_inst_d;
  end
endmodule
